// File: rtl/multicycle_controller.sv
// Purpose: Moore FSM sequencing a multi-cycle RV32I datapath (fetch/decode/execute/memory/writeback).
// Latency: outputs decode from the current state in the same cycle; one state transition per clock.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold until mem_ready; a bounded wait escalates to TRAP.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       Z,
    input  logic       S,
    input  logic       U,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic       trap,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALR_PC  = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             is_wait;
    logic             timeout_hit;
    logic             br_taken;

    // Memory-wait states share one counter; a zero timeout disables the escape to TRAP.
    assign is_wait     = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    // Branch condition from the ALU compare flags of rs1 - rs2.
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = Z;
            3'b001:  br_taken = !Z;
            3'b100:  br_taken = S;
            3'b101:  br_taken = !S;
            3'b110:  br_taken = U;
            3'b111:  br_taken = !U;
            default: br_taken = 1'b0;
        endcase
    end

    // Next-state selection; mem_ready in the final wait cycle beats the timeout.
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: begin
                if (mem_ready)        next_state = S_DECODE;
                else if (timeout_hit) next_state = S_TRAP;
            end
            S_DECODE: begin
                case (opcode)
                    7'b0000011, 7'b0100011: next_state = S_MEMADR;
                    7'b0110011:             next_state = S_EXEC_R;
                    7'b0010011:             next_state = S_EXEC_I;
                    7'b1100011:             next_state = S_BRANCH;
                    7'b1101111:             next_state = S_JAL;
                    7'b1100111:             next_state = S_JALR;
                    7'b0110111:             next_state = S_LUI;
                    7'b0010111:             next_state = S_AUIPC;
                    default:                next_state = S_TRAP;
                endcase
            end
            S_MEMADR:   next_state = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem_ready)        next_state = S_MEMWB;
                else if (timeout_hit) next_state = S_TRAP;
            end
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready)        next_state = S_FETCH;
                else if (timeout_hit) next_state = S_TRAP;
            end
            S_EXEC_R:   next_state = S_ALUWB;
            S_EXEC_I:   next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BRANCH:   next_state = (funct3 == 3'b010 || funct3 == 3'b011) ? S_TRAP : S_FETCH;
            S_JAL:      next_state = S_ALUWB;
            S_JALR:     next_state = S_JALR_PC;
            S_JALR_PC:  next_state = S_ALUWB;
            S_LUI:      next_state = S_ALUWB;
            S_AUIPC:    next_state = S_ALUWB;
            S_TRAP:     next_state = S_TRAP;
            default:    next_state = S_TRAP;
        endcase
    end

    // State and wait-counter registers; counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (next_state != state)
                wait_cnt <= '0;
            else if (is_wait && !mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Moore output decode; flag/ready-qualified strobes, everything squashed while rst is high.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        imm_src    = 3'b000;
        trap       = 1'b0;
        state_o    = state;
        case (opcode)
            7'b0100011:             imm_src = 3'b001;
            7'b1100011:             imm_src = 3'b010;
            7'b1101111:             imm_src = 3'b011;
            7'b0110111, 7'b0010111: imm_src = 3'b100;
            default:                imm_src = 3'b000;
        endcase
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR, S_EXEC_I, S_JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = (state == S_EXEC_I) ? 2'b10 : 2'b00;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_ALUWB:  reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = br_taken && !(funct3 == 3'b010 || funct3 == 3'b011);
            end
            S_JAL, S_JALR_PC: begin
                pc_write  = 1'b1;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
            end
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_TRAP: begin
                trap    = 1'b1;
                imm_src = 3'b000;
            end
            default: trap = 1'b1;
        endcase
        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            adr_src    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            result_src = 2'b00;
            imm_src    = 3'b000;
            trap       = 1'b0;
            state_o    = 4'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Purpose: directed-vector bench for multicycle_controller with hand-computed expectations.
// Latency: inputs change 1ns after a rising edge; outputs are sampled 1ns after that.
// Backpressure: mem_ready is withheld per vector to exercise wait and timeout paths.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       Z, S, U;
    logic       mem_ready;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0] imm_src;
    logic       trap;
    logic [3:0] state_o;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .Z(Z), .S(S), .U(U), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .imm_src(imm_src), .trap(trap), .state_o(state_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // FETCH completes immediately, DECODE dispatches; returns in the dispatched state.
    task automatic fetch_decode(input logic [6:0] op, input logic [2:0] f3);
        opcode    = op;
        funct3    = f3;
        mem_ready = 1'b1;
        settle();
        check("fd_fetch_state", 32'(state_o), 32'd0);
        check("fd_ir_write", 32'(ir_write), 32'd1);
        tick();
        mem_ready = 1'b0;
        settle();
        check("fd_decode_state", 32'(state_o), 32'd1);
        tick();
    endtask

    initial begin
        rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; Z = 0; S = 0; U = 0; mem_ready = 1'b0;
        tick();
        tick();
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        rst = 1'b0;

        // ADD
        opcode = 7'b0110011; mem_ready = 1'b1;
        settle();
        check("add_fetch_state", 32'(state_o), 32'd0);
        check("add_fetch_irw", 32'(ir_write), 32'd1);
        check("add_fetch_pcw", 32'(pc_write), 32'd1);
        check("add_fetch_b", 32'(alu_src_b), 32'd2);
        check("add_fetch_res", 32'(result_src), 32'd2);
        check("add_fetch_regw", 32'(reg_write), 32'd0);
        tick();
        mem_ready = 1'b0;
        settle();
        check("add_dec_state", 32'(state_o), 32'd1);
        check("add_dec_ab", 32'({alu_src_a, alu_src_b}), 32'h5);
        check("add_dec_pcw", 32'(pc_write), 32'd0);
        tick();
        check("add_exr_state", 32'(state_o), 32'd6);
        check("add_exr_op", 32'({alu_op, alu_src_a, alu_src_b}), 32'b10_10_00);
        check("add_exr_regw", 32'(reg_write), 32'd0);
        tick();
        check("add_wb_state", 32'(state_o), 32'd8);
        check("add_wb_regw", 32'(reg_write), 32'd1);
        tick();
        check("add_back_fetch", 32'(state_o), 32'd0);

        // LW, three cycles of wait in MEMREAD
        fetch_decode(7'b0000011, 3'b010);
        check("lw_memadr", 32'(state_o), 32'd2);
        check("lw_memadr_ab", 32'({alu_src_a, alu_src_b}), 32'b10_01);
        check("lw_imm", 32'(imm_src), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            settle();
            check("lw_mr_state", 32'(state_o), 32'd3);
            check("lw_mr_req_adr", 32'({mem_req, adr_src, mem_we}), 32'b110);
            tick();
        end
        mem_ready = 1'b0;
        check("lw_wb_state", 32'(state_o), 32'd4);
        check("lw_wb_regw_res", 32'({reg_write, result_src}), 32'b1_01);
        tick();
        check("lw_back_fetch", 32'(state_o), 32'd0);

        // BEQ taken / not taken, BLTU taken, illegal funct3
        fetch_decode(7'b1100011, 3'b000);
        Z = 1'b1; settle();
        check("beq_state", 32'(state_o), 32'd9);
        check("beq_z1_pcw", 32'(pc_write), 32'd1);
        check("beq_aluop", 32'(alu_op), 32'd1);
        check("beq_imm", 32'(imm_src), 32'd2);
        tick();
        check("beq_back_fetch", 32'(state_o), 32'd0);
        fetch_decode(7'b1100011, 3'b000);
        Z = 1'b0; settle();
        check("beq_z0_pcw", 32'(pc_write), 32'd0);
        tick();
        fetch_decode(7'b1100011, 3'b110);
        U = 1'b1; settle();
        check("bltu_u1_pcw", 32'(pc_write), 32'd1);
        tick();
        U = 1'b0;
        fetch_decode(7'b1100011, 3'b010);
        Z = 1'b1; settle();
        check("b010_pcw", 32'(pc_write), 32'd0);
        tick();
        Z = 1'b0;
        check("b010_trap_state", 32'(state_o), 32'd15);
        check("b010_trap", 32'(trap), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;

        // JALR
        fetch_decode(7'b1100111, 3'b000);
        check("jalr_state", 32'(state_o), 32'd11);
        check("jalr_ab_op", 32'({alu_src_a, alu_src_b, alu_op}), 32'b10_01_00);
        check("jalr_imm", 32'(imm_src), 32'd0);
        tick();
        check("jalrpc_state", 32'(state_o), 32'd12);
        check("jalrpc_pcw_ab", 32'({pc_write, alu_src_a, alu_src_b}), 32'b1_01_10);
        check("jalrpc_imm", 32'(imm_src), 32'd0);
        tick();
        check("jalr_wb_state", 32'(state_o), 32'd8);
        check("jalr_wb_regw", 32'(reg_write), 32'd1);
        check("jalr_wb_imm", 32'(imm_src), 32'd0);
        tick();

        // SW, memory never responds
        fetch_decode(7'b0100011, 3'b010);
        check("sw_imm", 32'(imm_src), 32'd1);
        tick();
        for (int i = 0; i < 16; i++) begin
            check("sw_wait_state", 32'(state_o), 32'd5);
            check("sw_wait_we", 32'(mem_we), 32'd1);
            tick();
        end
        check("sw_timeout_state", 32'(state_o), 32'd15);
        check("sw_timeout_we", 32'({mem_we, mem_req, trap}), 32'b001);
        tick();
        check("sw_trap_sticky", 32'(trap), 32'd1);
        rst = 1'b1; settle();
        check("sw_rst_state", 32'(state_o), 32'd0);
        check("sw_rst_trap", 32'(trap), 32'd0);
        tick(); rst = 1'b0; settle();
        check("sw_rst_fetch", 32'({state_o, mem_req}), 32'b0000_1);

        // Illegal opcode
        fetch_decode(7'b1111111, 3'b000);
        check("illegal_state", 32'(state_o), 32'd15);
        check("illegal_trap", 32'(trap), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;

        // Reset mid MEMREAD wait
        fetch_decode(7'b0000011, 3'b000);
        tick();
        tick();
        check("lw2_wait_req", 32'({state_o, mem_req}), 32'b0011_1);
        rst = 1'b1; settle();
        check("lw2_rst_req", 32'({mem_req, adr_src}), 32'd0);
        check("lw2_rst_state", 32'(state_o), 32'd0);
        tick(); rst = 1'b0; settle();
        check("lw2_after_rst", 32'({state_o, mem_req, adr_src}), 32'b0000_10);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
